// File: rtl/fixed_cast_pkg.sv
// Shared helpers for the fixed-point cast path: saturation bounds and per-lane flag type.
package fixed_cast_pkg;

  localparam int MAX_LANES = 32;

  typedef logic [MAX_LANES-1:0] cast_flags_t;

  function automatic logic signed [31:0] sat_max(input int width);
    return (32'sd1 <<< (width - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] sat_min(input int width);
    return -(32'sd1 <<< (width - 1));
  endfunction

  function automatic logic [31:0] popcount_flags(input cast_flags_t flags);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 32'(flags[i]);
    return n;
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice (main + skid); upstream ready is a pure register output.
module skid_buffer #(
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  main_valid_q;
  logic                  skid_valid_q;
  logic                  in_xfer;

  assign in_xfer        = data_in_valid && !skid_valid_q;
  assign data_in_ready  = !skid_valid_q;
  assign data_out       = main_q;
  assign data_out_valid = main_valid_q;

  // skid can only be occupied while main is also occupied
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (data_out_ready) begin
        main_q       <= skid_q;
        skid_valid_q <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_valid_q || data_out_ready) begin
        main_q       <= data_in;
        main_valid_q <= 1'b1;
      end else begin
        skid_q       <= data_in;
        skid_valid_q <= 1'b1;
      end
    end else if (data_out_ready) begin
      main_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fixed_saturate_stream.sv
// Clamps each guard-bit lane to the signed OUT_WIDTH range, flags saturated lanes, registers behind a skid buffer.
// Optional saturation counter port sat_count is built only with FIXED_SAT_COUNT_EN defined.
module fixed_saturate_stream
  import fixed_cast_pkg::*;
#(
  parameter int IN_WIDTH    = 9,
  parameter int OUT_WIDTH   = 8,
  parameter int PARALLELISM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [IN_WIDTH*PARALLELISM-1:0]  data_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  output logic [OUT_WIDTH*PARALLELISM-1:0] data_out_0,
  output logic [PARALLELISM-1:0]           data_out_0_sat,
  output logic                             data_out_0_valid,
  input  logic                             data_out_0_ready
`ifdef FIXED_SAT_COUNT_EN
  ,
  output logic [31:0]                      sat_count
`endif
);

  localparam int DW = PARALLELISM * (OUT_WIDTH + 1);
  localparam logic signed [IN_WIDTH-1:0] LANE_MAX = IN_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] LANE_MIN = IN_WIDTH'(sat_min(OUT_WIDTH));

  logic [OUT_WIDTH*PARALLELISM-1:0] clamp_data;
  logic [PARALLELISM-1:0]           clamp_sat;
  logic [DW-1:0]                    buf_out;

  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic signed [IN_WIDTH-1:0] lane_x;
    logic                       over;
    logic                       under;

    assign lane_x = data_in_0[i*IN_WIDTH +: IN_WIDTH];
    assign over   = lane_x > LANE_MAX;
    assign under  = lane_x < LANE_MIN;
    assign clamp_data[i*OUT_WIDTH +: OUT_WIDTH] = over  ? LANE_MAX[OUT_WIDTH-1:0] :
                                                  under ? LANE_MIN[OUT_WIDTH-1:0] :
                                                          lane_x[OUT_WIDTH-1:0];
    assign clamp_sat[i] = over | under;
  end

  skid_buffer #(
    .DATA_WIDTH(DW)
  ) u_skid (
    .clk           (clk),
    .rst           (rst),
    .data_in       ({clamp_sat, clamp_data}),
    .data_in_valid (data_in_0_valid),
    .data_in_ready (data_in_0_ready),
    .data_out      (buf_out),
    .data_out_valid(data_out_0_valid),
    .data_out_ready(data_out_0_ready)
  );

  assign data_out_0     = buf_out[OUT_WIDTH*PARALLELISM-1:0];
  assign data_out_0_sat = buf_out[DW-1 -: PARALLELISM];

`ifdef FIXED_SAT_COUNT_EN
  logic [31:0] sat_cnt_q;
  cast_flags_t flags_ext;
  logic [32:0] cnt_sum;

  always_comb begin
    flags_ext                   = '0;
    flags_ext[PARALLELISM-1:0] = data_out_0_sat;
  end

  assign cnt_sum = {1'b0, sat_cnt_q} + {1'b0, popcount_flags(flags_ext)};

  // counter saturates rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if (data_out_0_valid && data_out_0_ready) begin
      sat_cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule
